// File: rtl/sc_pkg.sv
// Shared types and constants for the stochastic dot-product accumulator:
// window FSM states, LFSR tap mask/seed and an elaboration-time clog2.
package sc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sc_state_e;

  // Fibonacci taps 16,14,13,11 expressed as a mask on bits [15:0]
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sc_lfsr_sel.sv
// Shared 16-bit Fibonacci LFSR producing the registered product-lane select.
// Reloads the seed at every window start so results are reproducible.
module sc_lfsr_sel
  import sc_pkg::*;
#(
  parameter logic [15:0] SEED  = LFSR_SEED_DEFAULT,
  parameter int          SEL_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             en_i,
  output logic [SEL_W-1:0] sel_o
);

  logic [15:0]      lfsr_q, lfsr_d;
  logic [SEL_W-1:0] sel_q, sel_d;

  always_comb begin
    lfsr_d = lfsr_q;
    sel_d  = sel_q;
    if (load_i) begin
      lfsr_d = SEED;
    end else if (en_i) begin
      // select is taken from the value before the step
      sel_d  = lfsr_q[SEL_W-1:0];
      lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= SEED;
      sel_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      sel_q  <= sel_d;
    end
  end

  assign sel_o = sel_q;

endmodule

// File: rtl/sc_dot_product_acc.sv
// Multi-channel stochastic dot product: per accepted bit each channel forms
// AND/XNOR products, picks one lane by shared LFSR select and counts ones.
module sc_dot_product_acc
  import sc_pkg::*;
#(
  parameter int          LENGTH      = 4,
  parameter int          CHANNELS    = 2,
  parameter int          STREAM_BITS = 8,
  parameter logic [15:0] SEED        = LFSR_SEED_DEFAULT
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                start_i,
  input  logic                                bipolar_i,
  input  logic                                in_valid_i,
  input  logic [LENGTH-1:0]                   data_i,
  input  logic [CHANNELS*LENGTH-1:0]          weights_i,
  output logic                                busy_o,
  output logic                                stream_valid_o,
  output logic [CHANNELS-1:0]                 result_stream_o,
  output logic                                done_o,
  output logic [CHANNELS*(STREAM_BITS+1)-1:0] count_o
);

  localparam int SEL_W = int'(clog2_f(LENGTH));
  localparam int CW    = STREAM_BITS + 1;

  if ((LENGTH < 2) || ((LENGTH & (LENGTH - 1)) != 0)) begin : g_bad_length
    $error("sc_dot_product_acc: LENGTH must be a power of two >= 2");
  end
  if (SEED == 16'h0000) begin : g_bad_seed
    $error("sc_dot_product_acc: SEED must be nonzero");
  end

  sc_state_e              state_q, state_d;
  logic                   mode_q, mode_d;
  logic [STREAM_BITS-1:0] bitcnt_q, bitcnt_d;
  logic                   prod_vld_q;
  logic [SEL_W-1:0]       sel_q;
  logic                   start_ok;
  logic                   accept;
  logic                   last_accept;

  assign start_ok    = (state_q == ST_IDLE) && start_i;
  assign accept      = (state_q == ST_RUN) && in_valid_i;
  assign last_accept = accept && (bitcnt_q == '0);

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    bitcnt_d = bitcnt_q;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d  = ST_RUN;
          mode_d   = bipolar_i;
          bitcnt_d = '1;
        end
      end
      ST_RUN: begin
        busy_o = 1'b1;
        if (accept) begin
          bitcnt_d = bitcnt_q - 1'b1;
          if (last_accept) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy_o  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      mode_q     <= 1'b0;
      bitcnt_q   <= '0;
      prod_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      bitcnt_q   <= bitcnt_d;
      prod_vld_q <= accept;
    end
  end

  sc_lfsr_sel #(
    .SEED  (SEED),
    .SEL_W (SEL_W)
  ) u_lfsr_sel (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (start_ok),
    .en_i   (accept),
    .sel_o  (sel_q)
  );

  assign stream_valid_o = prod_vld_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [LENGTH-1:0] w_c;
    logic [LENGTH-1:0] prod_q, prod_d;
    logic [CW-1:0]     count_q, count_d;
    logic              bit_c;

    assign w_c   = weights_i[c*LENGTH +: LENGTH];
    assign bit_c = prod_vld_q & prod_q[sel_q];

    always_comb begin
      prod_d  = prod_q;
      count_d = count_q;
      if (accept) prod_d = mode_q ? ~(data_i ^ w_c) : (data_i & w_c);
      // a full window of ones is exactly 2^STREAM_BITS, which fits in CW bits
      if (start_ok)        count_d = '0;
      else if (prod_vld_q) count_d = count_q + CW'(bit_c);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        prod_q  <= '0;
        count_q <= '0;
      end else begin
        prod_q  <= prod_d;
        count_q <= count_d;
      end
    end

    assign result_stream_o[c]    = bit_c;
    assign count_o[c*CW +: CW]   = count_q;
  end

endmodule

// File: tb/tb_sc_dot_product_acc.sv
// Scoreboard bench for sc_dot_product_acc: stimulus pushes per-bit and per-window
// expectations from a behavioural model; a negedge monitor pops and compares.
module tb_sc_dot_product_acc;

  localparam int          LEN  = 4;
  localparam int          CH   = 2;
  localparam int          SB   = 8;
  localparam int          CW   = SB + 1;
  localparam int          NWIN = 1 << SB;
  localparam logic [15:0] SEED = 16'hACE1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               bipolar = 1'b0;
  logic               in_valid = 1'b0;
  logic [LEN-1:0]     data = '0;
  logic [CH*LEN-1:0]  weights = '0;
  logic               busy;
  logic               stream_valid;
  logic [CH-1:0]      result_stream;
  logic               done;
  logic [CH*CW-1:0]   count;

  typedef struct {
    logic [CH*CW-1:0] cnt;
    int               busy_len;
  } win_t;

  logic [CH-1:0] exp_stream_q[$];
  win_t          exp_win_q[$];

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int busy_cnt = 0;

  logic [CH*CW-1:0] ref_t2;
  logic [CH*CW-1:0] tmp_cnt;

  sc_dot_product_acc #(
    .LENGTH(LEN), .CHANNELS(CH), .STREAM_BITS(SB), .SEED(SEED)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .bipolar_i(bipolar),
    .in_valid_i(in_valid), .data_i(data), .weights_i(weights),
    .busy_o(busy), .stream_valid_o(stream_valid), .result_stream_o(result_stream),
    .done_o(done), .count_o(count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      checks++;
      if (stream_valid) begin
        if (exp_stream_q.size() == 0) begin
          errors++;
          $display("FAIL stream_unexpected got=%b expected=none", result_stream);
        end else begin
          logic [CH-1:0] e;
          e = exp_stream_q.pop_front();
          if (result_stream !== e) begin
            errors++;
            $display("FAIL stream_bit got=%b expected=%b", result_stream, e);
          end
        end
      end else if (result_stream !== '0) begin
        errors++;
        $display("FAIL stream_idle got=%b expected=0", result_stream);
      end
      if (done) begin
        done_seen++;
        checks++;
        if (exp_win_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected count=%h", count);
        end else begin
          win_t w;
          w = exp_win_q.pop_front();
          if (count !== w.cnt) begin
            errors++;
            $display("FAIL window_count got=%h expected=%h", count, w.cnt);
          end
          checks++;
          if (busy_cnt != w.busy_len) begin
            errors++;
            $display("FAIL busy_len got=%0d expected=%0d", busy_cnt, w.busy_len);
          end
        end
        busy_cnt = 0;
      end
    end
  end

  // dmode: 0 fixed data/weights, 1 random per cycle
  // vmode: 0 always valid, 1 alternate starting valid, 2 random ~75%
  task automatic run_window(input bit bip, input int dmode,
                            input logic [LEN-1:0] dfix, input logic [CH*LEN-1:0] wfix,
                            input int vmode, input int start_poke, input int abort_at,
                            output logic [CH*CW-1:0] ecnt);
    logic [15:0]   l;
    int            acc, run_cyc, seen0;
    bit            v;
    logic [CH-1:0] sbit;
    logic [LEN-1:0] w, p;
    @(posedge clk); #1;
    start    = 1'b1;
    bipolar  = bip;
    in_valid = 1'($urandom_range(0, 1));
    data     = LEN'($urandom);
    weights  = (CH*LEN)'($urandom);
    l = SEED; acc = 0; run_cyc = 0; ecnt = '0;
    while (acc < NWIN) begin
      @(posedge clk); #1;
      if (abort_at >= 0 && acc == abort_at) begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b1;
        #1;
        checks++;
        if ({busy, stream_valid, result_stream, done, count} !== '0) begin
          errors++;
          $display("FAIL abort_outputs busy=%b sv=%b rs=%b done=%b count=%h expected=all0",
                   busy, stream_valid, result_stream, done, count);
        end
        exp_stream_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      run_cyc++;
      start = (start_poke > 0 && run_cyc == start_poke);
      data    = dmode ? LEN'($urandom) : dfix;
      weights = dmode ? (CH*LEN)'($urandom) : wfix;
      case (vmode)
        0:       v = 1'b1;
        1:       v = (run_cyc % 2) == 1;
        default: v = $urandom_range(0, 3) != 0;
      endcase
      in_valid = v;
      if (v) begin
        for (int c = 0; c < CH; c++) begin
          w = weights[c*LEN +: LEN];
          p = bip ? ~(data ^ w) : (data & w);
          sbit[c] = p[int'(l) % LEN];
          ecnt[c*CW +: CW] = ecnt[c*CW +: CW] + CW'(sbit[c]);
        end
        exp_stream_q.push_back(sbit);
        l = lfsr_next(l);
        acc++;
      end
    end
    exp_win_q.push_back('{ecnt, run_cyc + 1});
    seen0 = done_seen;
    // DRAIN then DONE: start and in_valid must both be ignored
    repeat (2) begin
      @(posedge clk); #1;
      start    = 1'b1;
      in_valid = 1'($urandom_range(0, 1));
      data     = LEN'($urandom);
    end
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 10 && done_seen == seen0; k++) @(posedge clk);
    checks++;
    if (done_seen != seen0 + 1) begin
      errors++;
      $display("FAIL done_pulse got=%0d expected=%0d", done_seen - seen0, 1);
    end
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (count !== ecnt) begin
      errors++;
      $display("FAIL count_hold got=%h expected=%h", count, ecnt);
    end
    checks++;
    if (exp_stream_q.size() != 0) begin
      errors++;
      $display("FAIL stream_leftover got=%0d expected=0", exp_stream_q.size());
    end
  endtask

  initial begin
    #1;
    checks++;
    if ({busy, stream_valid, result_stream, done, count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h expected=0",
               {busy, stream_valid, result_stream, done, count});
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: all ones
    run_window(1'b0, 0, 4'hF, 8'hFF, 0, 0, -1, tmp_cnt);
    checks++;
    if (count !== {CW'(NWIN), CW'(NWIN)}) begin
      errors++;
      $display("FAIL t1_full got=%h expected=%h", count, {CW'(NWIN), CW'(NWIN)});
    end

    // 2: lane-0 only data, ch0 all weights, ch1 none
    run_window(1'b0, 0, 4'h1, 8'h0F, 0, 0, -1, ref_t2);
    checks++;
    if (count[CW +: CW] !== '0) begin
      errors++;
      $display("FAIL t2_ch1 got=%0d expected=0", count[CW +: CW]);
    end

    // 3: bipolar identical / opposite
    run_window(1'b1, 0, 4'hF, 8'h0F, 0, 0, -1, tmp_cnt);
    checks++;
    if (count !== {CW'(0), CW'(NWIN)}) begin
      errors++;
      $display("FAIL t3_bipolar got=%h expected=%h", count, {CW'(0), CW'(NWIN)});
    end

    // 4: alternating in_valid
    run_window(1'b0, 0, 4'h1, 8'h0F, 1, 0, -1, tmp_cnt);
    checks++;
    if (count !== ref_t2) begin
      errors++;
      $display("FAIL t4_gapped got=%h expected=%h", count, ref_t2);
    end

    // 5: start pokes mid-window, then back-to-back repeat
    run_window(1'b0, 0, 4'h1, 8'h0F, 0, 37, -1, tmp_cnt);
    checks++;
    if (count !== ref_t2) begin
      errors++;
      $display("FAIL t5_poke got=%h expected=%h", count, ref_t2);
    end
    run_window(1'b0, 0, 4'h1, 8'h0F, 0, 200, -1, tmp_cnt);
    checks++;
    if (count !== ref_t2) begin
      errors++;
      $display("FAIL t5_repeat got=%h expected=%h", count, ref_t2);
    end

    // 6: reset at accept 100, then clean window
    run_window(1'b0, 0, 4'h1, 8'h0F, 0, 0, 100, tmp_cnt);
    repeat (4) @(posedge clk);
    run_window(1'b0, 0, 4'h1, 8'h0F, 0, 0, -1, tmp_cnt);
    checks++;
    if (count !== ref_t2) begin
      errors++;
      $display("FAIL t6_after_reset got=%h expected=%h", count, ref_t2);
    end

    // random traffic in both modes
    for (int i = 0; i < 4; i++)
      run_window(1'(i), 1, '0, '0, 2, 0, -1, tmp_cnt);

    repeat (3) @(posedge clk);
    checks++;
    if (exp_win_q.size() != 0) begin
      errors++;
      $display("FAIL window_leftover got=%0d expected=0", exp_win_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
